// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
//
// Lets two requesters share one external combinational 4-bit ALU. Requests are
// granted round-robin. A granted operation is latched onto the ALU buses, given
// one cycle to settle, and then returned on a registered response port together
// with the requester id and an error flag. The arbiter replaces the ALU result
// for divide/modulo by zero and for opcodes the ALU does not implement.
//
// Parameters
//   FIRST_PRIO  requester that wins the first tie after reset (0 or 1)
//   DIVZ_VALUE  rsp_data returned for op 3 / op 10 with y == 0
//   NUM_OPS     opcodes 0..NUM_OPS-1 are legal, the rest report an error
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   req0_* / req1_*       valid/ready request ports: op, operand x, operand y.
//                         ready is combinational and high only in the cycle
//                         the operation is accepted
//   alu_in, alu_op        registered ALU buses: {y,x} and {4'h0,op}
//   alu_result            combinational ALU result for alu_in/alu_op
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/id/err       registered result, owning requester, error flag
//   done_cnt              completed responses, wraps 255 -> 0
// -----------------------------------------------------------------------------
module alu_req_arbiter #(
  parameter logic       FIRST_PRIO = 1'b0,
  parameter logic [7:0] DIVZ_VALUE = 8'hFF,
  parameter int         NUM_OPS    = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_op,
  input  logic [3:0] req0_x,
  input  logic [3:0] req0_y,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_op,
  input  logic [3:0] req1_x,
  input  logic [3:0] req1_y,
  output logic [7:0] alu_in,
  output logic [7:0] alu_op,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       rsp_err,
  output logic [7:0] done_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Five bits so that NUM_OPS = 16 (every opcode legal) still compares correctly.
  localparam logic [4:0] NUM_OPS_W = 5'(NUM_OPS);

  state_t     state_r;
  logic       last_r;      // requester served most recently
  logic       id_r;        // owner of the operation in flight

  logic       grant_any_s;
  logic       grant_id_s;
  logic [3:0] sel_op_s;
  logic [3:0] sel_x_s;
  logic [3:0] sel_y_s;

  logic [3:0] cur_op_s;
  logic [3:0] cur_y_s;
  logic [7:0] res_data_s;
  logic       res_err_s;

  // Round-robin grant: a lone requester always wins, a tie goes to the one not served last.
  always_comb begin
    grant_any_s = 1'b0;
    grant_id_s  = 1'b0;
    if (state_r == ST_IDLE) begin
      grant_any_s = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
        grant_id_s = ~last_r;
      end else if (req1_valid) begin
        grant_id_s = 1'b1;
      end else begin
        grant_id_s = 1'b0;
      end
    end else begin
      grant_any_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  assign req0_ready = grant_any_s & ~grant_id_s;
  assign req1_ready = grant_any_s &  grant_id_s;

  // Operand mux feeding the ALU bus registers at the accepting edge.
  always_comb begin
    sel_op_s = req0_op;
    sel_x_s  = req0_x;
    sel_y_s  = req0_y;
    if (grant_id_s) begin
      sel_op_s = req1_op;
      sel_x_s  = req1_x;
      sel_y_s  = req1_y;
    end else begin
      sel_op_s = req0_op;
      sel_x_s  = req0_x;
      sel_y_s  = req0_y;
    end
  end

  // The in-flight operation is read back from the registered ALU buses, so
  // requester inputs changing after acceptance cannot disturb it.
  assign cur_op_s = alu_op[3:0];
  assign cur_y_s  = alu_in[7:4];

  // Result override: an illegal opcode takes precedence over the divide-by-zero check.
  always_comb begin
    res_data_s = alu_result;
    res_err_s  = 1'b0;
    if ({1'b0, cur_op_s} >= NUM_OPS_W) begin
      res_data_s = 8'h00;
      res_err_s  = 1'b1;
    end else if (((cur_op_s == 4'd3) || (cur_op_s == 4'd10)) && (cur_y_s == 4'd0)) begin
      res_data_s = DIVZ_VALUE;
      res_err_s  = 1'b1;
    end else begin
      res_data_s = alu_result;
      res_err_s  = 1'b0;
    end
  end

  // Control FSM with registered ALU buses, response port and completion counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      last_r    <= ~FIRST_PRIO;
      id_r      <= 1'b0;
      alu_in    <= 8'h00;
      alu_op    <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      done_cnt  <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_any_s) begin
            alu_in  <= {sel_y_s, sel_x_s};
            alu_op  <= {4'h0, sel_op_s};
            id_r    <= grant_id_s;
            last_r  <= grant_id_s;
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // The ALU has had a full cycle to settle on the registered buses.
          rsp_data  <= res_data_s;
          rsp_err   <= res_err_s;
          rsp_id    <= id_r;
          rsp_valid <= 1'b1;
          state_r   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + 8'd1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
